// File: rtl/ex_stage_pkg.sv
// Shared EX definitions: ALU op codes, div_op bit positions, zip widths, divider states.
// Imported by ex_stage, ex_divider and the bench so encodings live in one place.
package ex_stage_pkg;

    localparam int ALU_OP_W = 4;
    localparam int DIV_OP_W = 3;
    localparam int RF_ZIP_W = 6;
    localparam int FWD_ZIP_W = 7;

    // id_div_op = {div_en, signed, want_remainder}
    localparam int DIV_EN_BIT = 2;
    localparam int DIV_SIGNED_BIT = 1;
    localparam int DIV_REM_BIT = 0;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Handshake between the EX stage and its iterative divider.
// master = EX control side, slave = divider.
interface ex_stage_if;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        ack;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output start, sgn, src1, src2, ack,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, sgn, src1, src2, ack,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/ex_divider.sv
// Restoring radix-2 divider, IDLE -> BUSY (32 steps) -> DONE; result held until ack.
// Signed ops divide magnitudes and fix signs at the output; divide by zero yields all-ones / src1.
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    ex_stage_if.slave  div
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dbz_q;

    logic [31:0] mag1, mag2;
    logic [32:0] trial, diff;

    assign mag1  = (div.sgn & div.src1[31]) ? -div.src1 : div.src1;
    assign mag2  = (div.sgn & div.src2[31]) ? -div.src2 : div.src2;

    // Dividend bits shift out of quo_q into the partial remainder one per step.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};

    always_comb begin
        state_d  = state_q;
        div.busy = 1'b0;
        div.done = 1'b0;
        case (state_q)
            DIV_IDLE: if (div.start) state_d = DIV_BUSY;
            DIV_BUSY: begin
                div.busy = 1'b1;
                if (cnt_q == 6'd31) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                div.done = 1'b1;
                if (div.ack) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DIV_IDLE: if (div.start) begin
                    cnt_q   <= 6'd0;
                    rem_q   <= 32'd0;
                    quo_q   <= mag1;
                    dvs_q   <= mag2;
                    q_neg_q <= div.sgn & (div.src1[31] ^ div.src2[31]);
                    r_neg_q <= div.sgn & div.src1[31];
                    dbz_q   <= (div.src2 == 32'd0);
                end
                DIV_BUSY: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= trial[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero divisor already leaves |src1| in rem_q; only the quotient needs overriding.
    assign div.quotient  = dbz_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_q : quo_q);
    assign div.remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: 1-cycle ALU, optional 34-cycle divider (EX_DIV_EN); holds while !mem_allowin.
// Memory enables are only raised in the cycle the instruction actually moves to MEM.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 ex_allowin,
    input  logic                 id_to_ex_valid,
    input  logic [31:0]          id_pc,
    input  logic [31:0]          id_alu_src1,
    input  logic [31:0]          id_alu_src2,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic [DIV_OP_W-1:0]  id_div_op,
    input  logic                 id_res_from_mem,
    input  logic                 id_mem_we,
    input  logic [31:0]          id_rkd_value,
    input  logic [RF_ZIP_W-1:0]  id_rf_zip,
    output logic                 ex_to_mem_valid,
    output logic [31:0]          ex_pc,
    output logic [31:0]          ex_alu_result,
    output logic [31:0]          ex_rkd_value,
    output logic                 ex_res_from_mem,
    output logic                 ex_mem_we,
    output logic [RF_ZIP_W-1:0]  ex_rf_zip,
    input  logic                 mem_allowin,
    output logic [FWD_ZIP_W-1:0] ex_fwd_zip
);

    logic                ex_valid;
    logic                ex_ready_go;
    logic [31:0]         pc_q;
    logic [31:0]         src1_q;
    logic [31:0]         src2_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                res_from_mem_q;
    logic                mem_we_q;
    logic [31:0]         rkd_q;
    logic [RF_ZIP_W-1:0] rf_zip_q;
    logic [31:0]         alu_res;
    logic [31:0]         ex_result;
    logic [4:0]          shamt;
`ifdef EX_DIV_EN
    logic [DIV_OP_W-1:0] div_op_q;
`endif

    assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
    assign ex_to_mem_valid = ex_valid & ex_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_valid       <= 1'b0;
            pc_q           <= 32'd0;
            src1_q         <= 32'd0;
            src2_q         <= 32'd0;
            alu_op_q       <= 4'd0;
            res_from_mem_q <= 1'b0;
            mem_we_q       <= 1'b0;
            rkd_q          <= 32'd0;
            rf_zip_q       <= '0;
`ifdef EX_DIV_EN
            div_op_q       <= '0;
`endif
        end else begin
            if (ex_allowin) ex_valid <= id_to_ex_valid;
            if (id_to_ex_valid && ex_allowin) begin
                pc_q           <= id_pc;
                src1_q         <= id_alu_src1;
                src2_q         <= id_alu_src2;
                alu_op_q       <= id_alu_op;
                res_from_mem_q <= id_res_from_mem;
                mem_we_q       <= id_mem_we;
                rkd_q          <= id_rkd_value;
                rf_zip_q       <= id_rf_zip;
`ifdef EX_DIV_EN
                div_op_q       <= id_div_op;
`endif
            end
        end
    end

    assign shamt = src2_q[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (alu_op_q)
            ALU_ADD:  alu_res = src1_q + src2_q;
            ALU_SUB:  alu_res = src1_q - src2_q;
            ALU_SLT:  alu_res = {31'd0, $signed(src1_q) < $signed(src2_q)};
            ALU_SLTU: alu_res = {31'd0, src1_q < src2_q};
            ALU_AND:  alu_res = src1_q & src2_q;
            ALU_OR:   alu_res = src1_q | src2_q;
            ALU_NOR:  alu_res = ~(src1_q | src2_q);
            ALU_XOR:  alu_res = src1_q ^ src2_q;
            ALU_SLL:  alu_res = src1_q << shamt;
            ALU_SRL:  alu_res = src1_q >> shamt;
            ALU_SRA:  alu_res = $signed(src1_q) >>> shamt;
            ALU_LUI:  alu_res = src2_q;
            default:  alu_res = 32'd0;
        endcase
    end

`ifdef EX_DIV_EN
    ex_stage_if div_bus ();
    logic is_div;

    assign is_div        = div_op_q[DIV_EN_BIT];
    // Gate start on busy/done so a waiting result is never overwritten by a restart.
    assign div_bus.start = ex_valid & is_div & ~div_bus.busy & ~div_bus.done;
    assign div_bus.sgn   = div_op_q[DIV_SIGNED_BIT];
    assign div_bus.src1  = src1_q;
    assign div_bus.src2  = src2_q;
    assign div_bus.ack   = mem_allowin;

    ex_divider u_divider (
        .clk    (clk),
        .resetn (resetn),
        .div    (div_bus)
    );

    assign ex_ready_go = ~is_div | div_bus.done;
    assign ex_result   = ~is_div ? alu_res :
                         (div_op_q[DIV_REM_BIT] ? div_bus.remainder : div_bus.quotient);
`else
    logic unused_div_op;

    assign unused_div_op = ^id_div_op;
    assign ex_ready_go   = 1'b1;
    assign ex_result     = alu_res;
`endif

    assign ex_pc           = pc_q;
    assign ex_alu_result   = ex_result;
    assign ex_rkd_value    = rkd_q;
    assign ex_rf_zip       = rf_zip_q;
    assign ex_res_from_mem = res_from_mem_q & ex_valid & ex_ready_go & mem_allowin;
    assign ex_mem_we       = mem_we_q & ex_valid & ex_ready_go & mem_allowin;
    assign ex_fwd_zip      = {ex_valid & rf_zip_q[RF_ZIP_W-1], rf_zip_q[RF_ZIP_W-2:0], res_from_mem_q};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed corner cases plus random traffic, scored against a queue-based model.
module tb_ex_stage;
    import ex_stage_pkg::*;

`ifdef EX_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rkd;
        logic [3:0]  op;
        logic [2:0]  divop;
        logic        rfm;
        logic        we;
        logic [5:0]  zip;
    } txn_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] rkd;
        logic [5:0]  zip;
        logic        rfm;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_allowin;
    logic        id_to_ex_valid;
    logic [31:0] id_pc, id_alu_src1, id_alu_src2, id_rkd_value;
    logic [3:0]  id_alu_op;
    logic [2:0]  id_div_op;
    logic        id_res_from_mem, id_mem_we;
    logic [5:0]  id_rf_zip;
    logic        ex_to_mem_valid;
    logic [31:0] ex_pc, ex_alu_result, ex_rkd_value;
    logic        ex_res_from_mem, ex_mem_we;
    logic [5:0]  ex_rf_zip;
    logic        mem_allowin;
    logic [6:0]  ex_fwd_zip;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   rand_bp = 1'b0;
    logic [31:0] pc_ctr = 32'h1c00_0000;

    ex_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_allowin      (ex_allowin),
        .id_to_ex_valid  (id_to_ex_valid),
        .id_pc           (id_pc),
        .id_alu_src1     (id_alu_src1),
        .id_alu_src2     (id_alu_src2),
        .id_alu_op       (id_alu_op),
        .id_div_op       (id_div_op),
        .id_res_from_mem (id_res_from_mem),
        .id_mem_we       (id_mem_we),
        .id_rkd_value    (id_rkd_value),
        .id_rf_zip       (id_rf_zip),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_pc           (ex_pc),
        .ex_alu_result   (ex_alu_result),
        .ex_rkd_value    (ex_rkd_value),
        .ex_res_from_mem (ex_res_from_mem),
        .ex_mem_we       (ex_mem_we),
        .ex_rf_zip       (ex_rf_zip),
        .mem_allowin     (mem_allowin),
        .ex_fwd_zip      (ex_fwd_zip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ALU semantics from plain operators, division via 64-bit host arithmetic.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        logic [31:0] r, q, rm;
        longint      sa, sb;
        longint unsigned ua, ub;
        case (t.op)
            ALU_ADD:  r = t.a + t.b;
            ALU_SUB:  r = t.a - t.b;
            ALU_SLT:  r = ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (t.a < t.b) ? 32'd1 : 32'd0;
            ALU_AND:  r = t.a & t.b;
            ALU_OR:   r = t.a | t.b;
            ALU_NOR:  r = ~(t.a | t.b);
            ALU_XOR:  r = t.a ^ t.b;
            ALU_SLL:  r = t.a << t.b[4:0];
            ALU_SRL:  r = t.a >> t.b[4:0];
            ALU_SRA:  r = $signed(t.a) >>> t.b[4:0];
            ALU_LUI:  r = t.b;
            default:  r = 32'd0;
        endcase
        if (DIV_ON && t.divop[2]) begin
            if (t.b == 32'd0) begin
                q  = 32'hFFFF_FFFF;
                rm = t.a;
            end else if (t.divop[1]) begin
                sa = longint'($signed(t.a));
                sb = longint'($signed(t.b));
                q  = 32'(sa / sb);
                rm = 32'(sa % sb);
            end else begin
                ua = {32'd0, t.a};
                ub = {32'd0, t.b};
                q  = 32'(ua / ub);
                rm = 32'(ua % ub);
            end
            r = t.divop[0] ? rm : q;
        end
        e.pc  = t.pc;
        e.res = r;
        e.rkd = t.rkd;
        e.zip = t.zip;
        e.rfm = t.rfm;
        e.we  = t.we;
        return e;
    endfunction

    function automatic txn_t mk(input logic [3:0] op, input logic [2:0] divop,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rfm, input logic we, input logic [5:0] zip);
        txn_t t;
        pc_ctr  = pc_ctr + 32'd4;
        t.pc    = pc_ctr;
        t.a     = a;
        t.b     = b;
        t.rkd   = $urandom;
        t.op    = op;
        t.divop = divop;
        t.rfm   = rfm;
        t.we    = we;
        t.zip   = zip;
        return t;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the instruction was taken.
    task automatic issue(input txn_t t);
        bit acc = 1'b0;
        id_pc           = t.pc;
        id_alu_src1     = t.a;
        id_alu_src2     = t.b;
        id_alu_op       = t.op;
        id_div_op       = t.divop;
        id_res_from_mem = t.rfm;
        id_mem_we       = t.we;
        id_rkd_value    = t.rkd;
        id_rf_zip       = t.zip;
        id_to_ex_valid  = 1'b1;
        for (int w = 0; w < 200 && !acc; w++) begin
            @(negedge clk);
            if (ex_allowin) acc = 1'b1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ex_allowin stayed %0b, required 1", ex_allowin);
        end
        @(posedge clk);
        if (acc) exp_q.push_back(model(t));
        #1 id_to_ex_valid = 1'b0;
    endtask

    task automatic wait_allowin(output int n);
        bit got = 1'b0;
        n = 0;
        for (int w = 0; w < 100 && !got; w++) begin
            @(negedge clk);
            if (ex_allowin) got = 1'b1;
            else n++;
        end
    endtask

    task automatic run_div(input string name, input logic [2:0] divop,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        txn_t t;
        int   n;
        t = mk(ALU_ADD, divop, a, b, 1'b0, 1'b0, {1'b1, 5'd9});
        issue(t);
        wait_allowin(n);
        chk({name, "_stall_cycles"}, n, DIV_ON ? 33 : 0);
        chk({name, "_valid"}, ex_to_mem_valid, 1'b1);
        chk({name, "_result"}, ex_alu_result, DIV_ON ? expv : a + b);
        @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rand_bp) mem_allowin = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every transfer to MEM must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && ex_to_mem_valid) begin
            if (mem_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: pc %0h with empty scoreboard", ex_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_transfer",
                        {ex_pc, ex_alu_result, ex_rkd_value, ex_rf_zip, ex_res_from_mem, ex_mem_we},
                        e);
                end
            end else begin
                chk("stall_mem_enables", {ex_res_from_mem, ex_mem_we}, 2'b00);
            end
        end
    end

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        txn_t t;
        int   n;
        bit   drained;

        resetn          = 1'b0;
        mem_allowin     = 1'b1;
        id_to_ex_valid  = 1'b0;
        id_pc           = 32'd0;
        id_alu_src1     = 32'd0;
        id_alu_src2     = 32'd0;
        id_alu_op       = 4'd0;
        id_div_op       = 3'd0;
        id_res_from_mem = 1'b0;
        id_mem_we       = 1'b0;
        id_rkd_value    = 32'd0;
        id_rf_zip       = 6'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_valid", ex_to_mem_valid, 1'b0);
        chk("rst_allowin", ex_allowin, 1'b1);
        chk("rst_result", ex_alu_result, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_fwd_zip", ex_fwd_zip, 7'd0);
        chk("rst_mem_en", {ex_res_from_mem, ex_mem_we, ex_rf_zip}, 8'd0);
        @(posedge clk);
        #1;

        // ADD 5+7 leaves EX the cycle after entry
        t = mk(ALU_ADD, 3'b000, 32'd5, 32'd7, 1'b0, 1'b0, {1'b1, 5'd3});
        issue(t);
        @(negedge clk);
        chk("add_valid", ex_to_mem_valid, 1'b1);
        chk("add_result", ex_alu_result, 32'd12);
        chk("add_fwd_zip", ex_fwd_zip, {1'b1, 5'd3, 1'b0});
        @(posedge clk);
        #1;

        // Load held by MEM: enables stay low until mem_allowin
        mem_allowin = 1'b0;
        t = mk(ALU_ADD, 3'b000, 32'h800, 32'h800, 1'b1, 1'b0, {1'b1, 5'd4});
        issue(t);
        @(negedge clk);
        chk("ld_stall_rfm", ex_res_from_mem, 1'b0);
        chk("ld_stall_allowin", ex_allowin, 1'b0);
        chk("ld_stall_result", ex_alu_result, 32'h1000);
        chk("ld_fwd_zip", ex_fwd_zip, {1'b1, 5'd4, 1'b1});
        @(posedge clk);
        #1 mem_allowin = 1'b1;
        @(negedge clk);
        chk("ld_rfm", ex_res_from_mem, 1'b1);
        chk("ld_result", ex_alu_result, 32'h1000);
        @(posedge clk);
        #1;

        run_div("divu_100_7", 3'b100, 32'd100, 32'd7, 32'd14);
        run_div("modu_100_7", 3'b101, 32'd100, 32'd7, 32'd2);
        run_div("div_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("divu_9_0", 3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_div("modu_9_0", 3'b101, 32'd9, 32'd0, 32'd9);

        // Result waits in DONE while MEM refuses
        mem_allowin = 1'b0;
        t = mk(ALU_ADD, 3'b100, 32'd1000, 32'd3, 1'b0, 1'b0, {1'b1, 5'd7});
        issue(t);
        n = 0;
        while (!ex_to_mem_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", ex_to_mem_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", ex_to_mem_valid, 1'b1);
            chk("hold_result", ex_alu_result, DIV_ON ? 32'd333 : 32'd1003);
            chk("hold_allowin", ex_allowin, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 mem_allowin = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_no_restart", ex_to_mem_valid, 1'b0);
        chk("hold_released_allowin", ex_allowin, 1'b1);
        @(posedge clk);
        #1;

        // Reset during BUSY cycle 10 kills the divide
        t = mk(ALU_ADD, 3'b100, 32'd12345, 32'd7, 1'b0, 1'b0, {1'b1, 5'd2});
        issue(t);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_valid", ex_to_mem_valid, 1'b0);
        chk("midrst_allowin", ex_allowin, 1'b1);
        chk("midrst_fwd_zip", ex_fwd_zip, 7'd0);
        @(posedge clk);
        #1;
        t = mk(ALU_ADD, 3'b000, 32'd3, 32'd4, 1'b0, 1'b0, {1'b1, 5'd5});
        issue(t);
        @(negedge clk);
        chk("postrst_add_valid", ex_to_mem_valid, 1'b1);
        chk("postrst_add_result", ex_alu_result, 32'd7);
        @(posedge clk);
        #1;
        run_div("postrst_divu", 3'b100, 32'd50, 32'd5, 32'd10);

        // Random traffic with random MEM backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            t = mk(4'($urandom_range(0, 11)),
                   {($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))},
                   pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            issue(t);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2 mem_allowin = 1'b1;
        drained = 1'b0;
        for (int w = 0; w < 200 && !drained; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        chk("drain_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state changes on posedge.
REQ-002 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: ex_allowin  output  1  EX may accept a new instruction this cycle.
REQ-004 SHALL have port: id_to_ex_valid  input  1  upstream instruction valid.
REQ-005 SHALL have ports: id_pc  input  32  instruction PC; id_alu_src1 and id_alu_src2  input  32 each  operands.
REQ-006 SHALL have port: id_alu_op  input  4  ALU op code (from shared header).
REQ-007 SHALL have port: id_div_op  input  3  {div_en, signed, want_remainder}.
REQ-008 SHALL have ports: id_res_from_mem  input  1  load; id_mem_we  input  1  store; id_rkd_value  input  32  store data.
REQ-009 SHALL have port: id_rf_zip  input  6  {rf_we, rf_waddr}.
REQ-010 SHALL have ports: ex_to_mem_valid  output  1; ex_pc  output  32; ex_alu_result  output  32; ex_rkd_value  output  32.
REQ-011 SHALL have ports: ex_res_from_mem and ex_mem_we  output  1 each; ex_rf_zip  output  6.
REQ-012 SHALL have port: mem_allowin  input  1  MEM can accept.
REQ-013 SHALL have port: ex_fwd_zip  output  7  {ex_valid & rf_we, rf_waddr, res_from_mem} for ID hazard logic.

Function
REQ-014 SHALL hold ex_valid; ex_allowin = ~ex_valid | (ex_ready_go & mem_allowin); ex_to_mem_valid = ex_valid & ex_ready_go.
REQ-015 SHALL latch all id_* payload registers only on id_to_ex_valid & ex_allowin; ex_valid <= id_to_ex_valid when ex_allowin.
REQ-016 SHALL compute ALU ops ADD, SUB, SLT, SLTU, AND, OR, NOR, XOR, SLL, SRL, SRA, LUI combinationally, 32-bit, wrap on overflow; shifts use src2[4:0].
REQ-017 SHALL drive ex_res_from_mem and ex_mem_we as the latched values gated by ex_valid & ex_ready_go & mem_allowin; MEM uses them directly as SRAM enables.
REQ-018 SHALL assert ex_ready_go = 1 for non-divide ops; ex_alu_result = ALU result.
REQ-019 SHALL run divide ops through a divider FSM with states IDLE -> BUSY -> DONE.
REQ-020 SHALL leave IDLE for BUSY on the first cycle ex_valid & div_en holds, capturing operand magnitudes.
REQ-021 SHALL perform one restoring radix-2 step per BUSY cycle, 32 cycles, 6-bit counter, then enter DONE.
REQ-022 SHALL hold ex_ready_go = 1 and the result register only in DONE, and SHALL return to IDLE when mem_allowin is asserted.
REQ-023 SHALL make total divide latency 34 cycles from EX entry to ex_to_mem_valid.
REQ-024 SHALL apply signed-op sign rules: quotient sign = src1 sign XOR src2 sign; remainder sign = src1 sign.
REQ-025 SHALL return, on divide by zero, quotient 32'hFFFFFFFF and remainder = src1, with normal latency.
REQ-026 SHALL select output by want_remainder: quotient if 0, remainder if 1.
REQ-027 SHALL NOT start a new divide while in BUSY or DONE.

Reset
REQ-028 SHALL on resetn low set ex_valid=0, divider state=IDLE, counter=0, and all outputs low/zero, including mid-divide; payload registers need no reset.

Configuration
REQ-029 SHALL instantiate the divider when macro EX_DIV_EN is defined.
REQ-030 SHALL, without EX_DIV_EN, omit the divider, ignore id_div_op, tie ex_ready_go=1, and use ALU result for all ops.

Structure
REQ-031 SHALL place ALU op codes, div_op bit positions and zip widths in shared header ex_defs.vh.
REQ-032 SHALL implement the FSM and datapath in sub-module ex_divider (start, signed, operands in; busy, done, quotient, remainder out; ack in).

Verification
REQ-033 SHALL test ADD 5+7, mem_allowin=1 -> ex_alu_result=12 and ex_to_mem_valid the cycle after entry.
REQ-034 SHALL test load at src1+src2=0x1000 -> ex_res_from_mem=1, ex_alu_result=0x1000; with mem_allowin=0 -> ex_res_from_mem=0 and ex_allowin=0.
REQ-035 SHALL test DIVU 100/7 -> ex_allowin=0 for 33 cycles, then result 14; MODU -> 2.
REQ-036 SHALL test signed DIV -7/2 -> 0xFFFFFFFD; MOD -> 0xFFFFFFFF; DIVU 9/0 -> 0xFFFFFFFF, MODU -> 9.
REQ-037 SHALL test DONE with mem_allowin held 0 for 5 cycles -> result stable, ex_valid held, no restart.
REQ-038 SHALL test resetn low at BUSY cycle 10 -> IDLE, ex_valid=0; next ADD completes normally.
